// File: rtl/xgs_grab_trigger_ctrl.sv
// Grab trigger qualifier: selects and conditions the trigger source, applies the
// programmed delay and hands one trigger per frame to the XGS sequencer.
module xgs_grab_trigger_ctrl #(
   parameter int FILTER_W = 8,
   parameter int DELAY_W  = 16,
   parameter int CNT_W    = 16
) (
   input  logic                sys_clk,
   input  logic                sys_reset_n,
   input  logic                grab_cmd,
   input  logic                grab_abort,
   input  logic [2:0]          grab_mode,
   input  logic [2:0]          grab_act,
   input  logic [FILTER_W-1:0] filter_len,
   input  logic [DELAY_W-1:0]  trig_delay,
   input  logic                hw_trig_in,
   input  logic                sw_trig,
   input  logic                sfnc_trig,
   input  logic                trig_ready,
   input  logic                frame_done,
   output logic                trig_valid,
   output logic                grab_active,
   output logic                missed_pulse,
   output logic [CNT_W-1:0]    missed_cnt
);

   localparam logic [2:0] MODE_IMMEDIATE = 3'd1;
   localparam logic [2:0] MODE_HW_TRIG   = 3'd2;
   localparam logic [2:0] MODE_SW_TRIG   = 3'd3;
   localparam logic [2:0] MODE_SFNC      = 3'd4;

   localparam logic [2:0] ACT_RISING   = 3'd0;
   localparam logic [2:0] ACT_FALLING  = 3'd1;
   localparam logic [2:0] ACT_ANY      = 3'd2;
   localparam logic [2:0] ACT_LEVEL_HI = 3'd3;
   localparam logic [2:0] ACT_LEVEL_LO = 3'd4;

   typedef enum logic [2:0] {IDLE, ARMED, DELAY, ISSUE, BUSY} state_t;

   state_t              state;
   logic [2:0]          mode_r;
   logic [2:0]          act_r;
   logic [DELAY_W-1:0]  delay_r;
   logic [DELAY_W-1:0]  dly_cnt;
   logic                sync1, sync2, filt, filt_prev;
   logic [FILTER_W-1:0] filt_cnt;
   logic                sw_r, sfnc_r;
   logic                edge_event, level_event, trig_event, miss_event;
   logic                mode_valid, miss_state;

   // The filter only follows the synced input once it has disagreed for filter_len+1 samples.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         filt      <= 1'b0;
         filt_cnt  <= '0;
         filt_prev <= 1'b0;
         sw_r      <= 1'b0;
         sfnc_r    <= 1'b0;
      end else begin
         sync1     <= hw_trig_in;
         sync2     <= sync1;
         filt_prev <= filt;
         sw_r      <= sw_trig;
         sfnc_r    <= sfnc_trig;
         if (sync2 != filt) begin
            if (filt_cnt == filter_len) begin
               filt     <= sync2;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   always_comb begin
      edge_event  = 1'b0;
      level_event = 1'b0;
      case (act_r)
         ACT_RISING:   edge_event  = filt & ~filt_prev;
         ACT_FALLING:  edge_event  = ~filt & filt_prev;
         ACT_ANY:      edge_event  = filt ^ filt_prev;
         ACT_LEVEL_HI: level_event = filt;
         ACT_LEVEL_LO: level_event = ~filt;
         default:      ;
      endcase
   end

   // Level and IMMEDIATE sources trigger but are never reported as missed.
   always_comb begin
      trig_event = 1'b0;
      miss_event = 1'b0;
      case (mode_r)
         MODE_IMMEDIATE: trig_event = 1'b1;
         MODE_HW_TRIG: begin
            trig_event = edge_event | level_event;
            miss_event = edge_event;
         end
         MODE_SW_TRIG: begin
            trig_event = sw_r;
            miss_event = sw_r;
         end
         MODE_SFNC: begin
            trig_event = sfnc_r;
            miss_event = sfnc_r;
         end
         default: ;
      endcase
   end

   assign mode_valid = (grab_mode >= MODE_IMMEDIATE) && (grab_mode <= MODE_SFNC);
   assign miss_state = (state == DELAY) || (state == ISSUE) || (state == BUSY);

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state        <= IDLE;
         mode_r       <= '0;
         act_r        <= '0;
         delay_r      <= '0;
         dly_cnt      <= '0;
         trig_valid   <= 1'b0;
         grab_active  <= 1'b0;
         missed_pulse <= 1'b0;
         missed_cnt   <= '0;
      end else begin
         missed_pulse <= 1'b0;
         if (miss_state && miss_event) begin
            missed_pulse <= 1'b1;
            if (missed_cnt != {CNT_W{1'b1}}) begin
               missed_cnt <= missed_cnt + 1'b1;
            end
         end
         if (grab_abort) begin
            state       <= IDLE;
            trig_valid  <= 1'b0;
            grab_active <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (grab_cmd && mode_valid) begin
                     state       <= ARMED;
                     grab_active <= 1'b1;
                     mode_r      <= grab_mode;
                     act_r       <= grab_act;
                     delay_r     <= trig_delay;
                     missed_cnt  <= '0;
                  end
               end
               ARMED: begin
                  if (trig_event) begin
                     if (delay_r == '0) begin
                        state      <= ISSUE;
                        trig_valid <= 1'b1;
                     end else begin
                        state   <= DELAY;
                        dly_cnt <= delay_r - 1'b1;
                     end
                  end
               end
               DELAY: begin
                  if (dly_cnt == '0) begin
                     state      <= ISSUE;
                     trig_valid <= 1'b1;
                  end else begin
                     dly_cnt <= dly_cnt - 1'b1;
                  end
               end
               ISSUE: begin
                  if (trig_ready) begin
                     state      <= BUSY;
                     trig_valid <= 1'b0;
                  end
               end
               BUSY: begin
                  if (frame_done) begin
                     state <= ARMED;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xgs_grab_trigger_ctrl.sv
// Directed-plus-random bench for xgs_grab_trigger_ctrl; expected latencies and miss
// counts come from closed-form rules, observed via negedge monitors.
module tb_xgs_grab_trigger_ctrl;

   localparam int FILTER_W = 8;
   localparam int DELAY_W  = 16;
   localparam int CNT_W    = 2;
   localparam int MAX_CNT  = (1 << CNT_W) - 1;

   logic                sys_clk;
   logic                sys_reset_n;
   logic                grab_cmd, grab_abort;
   logic [2:0]          grab_mode, grab_act;
   logic [FILTER_W-1:0] filter_len;
   logic [DELAY_W-1:0]  trig_delay;
   logic                hw_trig_in, sw_trig, sfnc_trig, trig_ready, frame_done;
   logic                trig_valid, grab_active, missed_pulse;
   logic [CNT_W-1:0]    missed_cnt;

   int checks = 0;
   int errors = 0;
   int valid_cycles = 0;
   int handshakes = 0;
   int miss_seen = 0;
   int n, lat, v0, h0, m0, flen, dly, mode, act;
   logic [2:0] bad_modes [4];

   xgs_grab_trigger_ctrl #(.FILTER_W(FILTER_W), .DELAY_W(DELAY_W), .CNT_W(CNT_W)) dut (
      .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
      .grab_cmd(grab_cmd), .grab_abort(grab_abort),
      .grab_mode(grab_mode), .grab_act(grab_act),
      .filter_len(filter_len), .trig_delay(trig_delay),
      .hw_trig_in(hw_trig_in), .sw_trig(sw_trig), .sfnc_trig(sfnc_trig),
      .trig_ready(trig_ready), .frame_done(frame_done),
      .trig_valid(trig_valid), .grab_active(grab_active),
      .missed_pulse(missed_pulse), .missed_cnt(missed_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Observed activity, sampled mid-cycle so every handshake and pulse is counted once.
   always @(negedge sys_clk) begin
      if (sys_reset_n) begin
         if (trig_valid === 1'b1) valid_cycles++;
         if (trig_valid === 1'b1 && trig_ready === 1'b1) handshakes++;
         if (missed_pulse === 1'b1) miss_seen++;
      end
   end

   function automatic int exp_latency(input int m, input int fl, input int d);
      if (m == 2) return fl + 4 + d;
      return 2 + d;
   endfunction

   function automatic int exp_missed(input int misses);
      return (misses > MAX_CNT) ? MAX_CNT : misses;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      grab_cmd   = 1'b0;
      grab_abort = 1'b0;
      sw_trig    = 1'b0;
      sfnc_trig  = 1'b0;
      frame_done = 1'b0;
   endtask

   task automatic wait_valid(input int max_cycles, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (trig_valid !== 1'b1 && cycles < max_cycles);
   endtask

   task automatic apply_stimulus(input int m, input int a, input int fl, input int d);
      grab_abort = 1'b1;
      tick();
      grab_mode  = 3'(m);
      grab_act   = 3'(a);
      filter_len = FILTER_W'(fl);
      trig_delay = DELAY_W'(d);
      grab_cmd   = 1'b1;
   endtask

   initial begin
      bad_modes = '{3'd0, 3'd5, 3'd6, 3'd7};
      sys_reset_n = 1'b0;
      grab_cmd = 0; grab_abort = 0; grab_mode = 0; grab_act = 0;
      filter_len = 0; trig_delay = 0; hw_trig_in = 0; sw_trig = 0;
      sfnc_trig = 0; trig_ready = 1; frame_done = 0;
      #23;
      check_output("rst_valid", trig_valid, 0);
      check_output("rst_active", grab_active, 0);
      check_output("rst_missed_pulse", missed_pulse, 0);
      check_output("rst_missed_cnt", missed_cnt, 0);
      @(posedge sys_clk); #1;
      sys_reset_n = 1'b1;
      repeat (3) tick();

      $display("[TB] IMMEDIATE");
      apply_stimulus(1, 0, 0, 0);
      wait_valid(20, n);
      check_output("imm_latency", n, exp_latency(1, 0, 0));
      check_output("imm_active", grab_active, 1);
      tick();
      check_output("imm_accepted", trig_valid, 0);
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(1, 5)) tick();
         frame_done = 1'b1;
         wait_valid(20, n);
         check_output("imm_rearm_latency", n, 2);
      end
      grab_abort = 1'b1;
      tick();
      check_output("imm_abort_active", grab_active, 0);
      check_output("imm_missed_cnt", missed_cnt, 0);

      $display("[TB] invalid mode");
      grab_mode = bad_modes[$urandom_range(0, 3)];
      grab_cmd = 1'b1;
      tick(); tick();
      check_output("invalid_mode_idle", grab_active, 0);

      $display("[TB] HW rising filter 3");
      apply_stimulus(2, 0, 3, 0);
      tick(); tick();
      v0 = valid_cycles;
      hw_trig_in = 1'b1;
      tick(); tick();
      hw_trig_in = 1'b0;
      repeat (15) tick();
      check_output("glitch_no_trig", valid_cycles - v0, 0);
      v0 = valid_cycles;
      lat = 0;
      hw_trig_in = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i == 10) hw_trig_in = 1'b0;
         if (trig_valid === 1'b1 && lat == 0) lat = i;
      end
      check_output("hw_pulse_latency", lat, exp_latency(2, 3, 0));
      check_output("hw_pulse_single", valid_cycles - v0, 1);

      for (int it = 0; it < 4; it++) begin
         flen = $urandom_range(0, 6);
         dly  = $urandom_range(0, 12);
         act  = ($urandom_range(0, 1) == 0) ? 0 : 2;
         grab_abort = 1'b1;
         repeat (flen + 8) tick();
         apply_stimulus(2, act, flen, dly);
         tick(); tick();
         v0 = valid_cycles;
         lat = 0;
         hw_trig_in = 1'b1;
         for (int i = 1; i <= flen + dly + 20; i++) begin
            tick();
            if (i == flen + 5) hw_trig_in = 1'b0;
            if (trig_valid === 1'b1 && lat == 0) lat = i;
         end
         check_output("hw_rand_latency", lat, exp_latency(2, flen, dly));
         check_output("hw_rand_single", valid_cycles - v0, 1);
         check_output("hw_rand_missed", missed_cnt, exp_missed(act == 2 ? 1 : 0));
      end

      $display("[TB] SW delay 100");
      apply_stimulus(3, 0, 0, 100);
      tick(); tick();
      sw_trig = 1'b1;
      wait_valid(140, n);
      check_output("sw_delay100_latency", n, exp_latency(3, 0, 100));

      for (int it = 0; it < 4; it++) begin
         mode = $urandom_range(3, 4);
         dly  = $urandom_range(0, 30);
         apply_stimulus(mode, $urandom_range(0, 7), 0, dly);
         tick(); tick();
         v0 = valid_cycles;
         if (mode == 3) sfnc_trig = 1'b1; else sw_trig = 1'b1;
         repeat (dly + 6) tick();
         check_output("wrong_source_ignored", valid_cycles - v0, 0);
         if (mode == 3) sw_trig = 1'b1; else sfnc_trig = 1'b1;
         wait_valid(dly + 30, n);
         check_output("sw_sfnc_latency", n, exp_latency(mode, 0, dly));
      end

      $display("[TB] missed triggers");
      apply_stimulus(2, 0, 0, 0);
      tick(); tick();
      hw_trig_in = 1'b1;
      wait_valid(20, n);
      check_output("miss_first_latency", n, exp_latency(2, 0, 0));
      tick();
      hw_trig_in = 1'b0;
      repeat (4) tick();
      for (int k = 1; k <= 5; k++) begin
         m0 = miss_seen;
         v0 = valid_cycles;
         hw_trig_in = 1'b1;
         repeat (3) tick();
         hw_trig_in = 1'b0;
         repeat (4) tick();
         check_output("miss_pulse_once", miss_seen - m0, 1);
         check_output("miss_cnt", missed_cnt, exp_missed(k));
         check_output("miss_no_trig", valid_cycles - v0, 0);
      end
      apply_stimulus(1, 0, 0, 0);
      tick();
      check_output("miss_cnt_cleared", missed_cnt, 0);

      $display("[TB] LEVEL_HI with stalled ready");
      trig_ready = 1'b0;
      apply_stimulus(2, 3, 2, 0);
      tick(); tick();
      h0 = handshakes;
      hw_trig_in = 1'b1;
      wait_valid(30, n);
      check_output("level_latency", n, exp_latency(2, 2, 0));
      v0 = valid_cycles;
      repeat (20) tick();
      check_output("level_valid_held", valid_cycles - v0, 20);
      check_output("level_valid_still", trig_valid, 1);
      trig_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(1, 4)) tick();
         frame_done = 1'b1;
         wait_valid(20, n);
         check_output("level_retrigger", n, 2);
         tick();
      end
      check_output("level_triggers", handshakes - h0, 4);
      check_output("level_missed_cnt", missed_cnt, 0);
      hw_trig_in = 1'b0;

      $display("[TB] aborts");
      apply_stimulus(3, 0, 0, 10);
      tick(); tick();
      v0 = valid_cycles;
      sw_trig = 1'b1;
      repeat (4) tick();
      grab_abort = 1'b1;
      repeat (20) tick();
      check_output("abort_delay_no_trig", valid_cycles - v0, 0);
      check_output("abort_delay_idle", grab_active, 0);

      trig_ready = 1'b0;
      apply_stimulus(3, 0, 0, 0);
      tick(); tick();
      sw_trig = 1'b1;
      wait_valid(20, n);
      check_output("abort_issue_latency", n, 2);
      grab_abort = 1'b1;
      tick();
      check_output("abort_issue_valid", trig_valid, 0);
      check_output("abort_issue_active", grab_active, 0);

      apply_stimulus(3, 0, 0, 0);
      tick(); tick();
      sw_trig = 1'b1;
      wait_valid(20, n);
      h0 = handshakes;
      grab_abort = 1'b1;
      trig_ready = 1'b1;
      tick();
      check_output("abort_ready_handshake", handshakes - h0, 1);
      check_output("abort_ready_valid", trig_valid, 0);
      frame_done = 1'b1;
      tick(); tick();
      check_output("abort_ready_untracked", grab_active, 0);

      $display("[TB] reset mid-BUSY");
      apply_stimulus(3, 0, 0, 0);
      tick(); tick();
      sw_trig = 1'b1;
      wait_valid(20, n);
      tick();
      sw_trig = 1'b1;
      repeat (3) tick();
      check_output("busy_missed_before_reset", missed_cnt, 1);
      #2;
      sys_reset_n = 1'b0;
      #1;
      check_output("reset_busy_valid", trig_valid, 0);
      check_output("reset_busy_active", grab_active, 0);
      check_output("reset_busy_missed_pulse", missed_pulse, 0);
      check_output("reset_busy_missed_cnt", missed_cnt, 0);
      tick(); tick();
      sys_reset_n = 1'b1;
      tick();
      check_output("reset_release_idle", grab_active, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
